// File: rtl/mtimer.sv
// mtimer: 64-bit machine timer with prescaler, compare register and level interrupt.
module mtimer #(
  parameter logic [7:0] PRESC_RST = 8'h00,
  parameter logic       EN_RST    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        timer_wr_en_i,
  input  logic [19:0] timer_wr_addr_i,
  input  logic [31:0] timer_wr_data_i,
  input  logic        timer_rd_en_i,
  input  logic [19:0] timer_rd_addr_i,
  output logic [31:0] timer_rd_data_o,
  output logic        timer_irq_o
);
  logic [63:0] mtime, mtimecmp, mtime_nx, cmp_nx;
  logic [31:0] hi_shadow, rd_sel;
  logic [7:0]  presc, presc_cnt;
  logic        en, irq_en, irq_en_nx;
  logic        wsel, rsel, we_lo, we_hi, we_clo, we_chi, we_ctrl, rd_lo, wrap, tick;
  logic [2:0]  widx, ridx;
  assign wsel    = timer_wr_en_i && timer_wr_addr_i[19:5] == 15'd0;
  assign rsel    = timer_rd_en_i && timer_rd_addr_i[19:5] == 15'd0;
  assign widx    = timer_wr_addr_i[4:2];
  assign ridx    = timer_rd_addr_i[4:2];
  assign we_lo   = wsel && widx == 3'd0;
  assign we_hi   = wsel && widx == 3'd1;
  assign we_clo  = wsel && widx == 3'd2;
  assign we_chi  = wsel && widx == 3'd3;
  assign we_ctrl = wsel && widx == 3'd4;
  assign rd_lo   = rsel && ridx == 3'd0;
  assign wrap    = presc_cnt == presc;
  // a CTRL write restarts the prescaler, so its cycle never ticks
  assign tick    = en && wrap && !we_ctrl;
  always_comb begin
    mtime_nx  = we_lo ? {mtime[63:32], timer_wr_data_i} :
                we_hi ? {timer_wr_data_i, mtime[31:0]} :
                tick  ? mtime + 64'd1 : mtime;
    cmp_nx    = we_clo ? {mtimecmp[63:32], timer_wr_data_i} :
                we_chi ? {timer_wr_data_i, mtimecmp[31:0]} : mtimecmp;
    irq_en_nx = we_ctrl ? timer_wr_data_i[1] : irq_en;
  end
  always_comb begin
    case (ridx)
      3'd0:    rd_sel = mtime[31:0];
      3'd1:    rd_sel = hi_shadow;
      3'd2:    rd_sel = mtimecmp[31:0];
      3'd3:    rd_sel = mtimecmp[63:32];
      3'd4:    rd_sel = {16'h0, presc, 6'h0, irq_en, en};
      3'd5:    rd_sel = {31'h0, mtime >= mtimecmp};
      default: rd_sel = 32'h0;
    endcase
    timer_rd_data_o = rsel ? rd_sel : 32'h0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      en          <= EN_RST;
      irq_en      <= 1'b0;
      presc       <= PRESC_RST;
      presc_cnt   <= '0;
      hi_shadow   <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      mtime       <= mtime_nx;
      mtimecmp    <= cmp_nx;
      irq_en      <= irq_en_nx;
      presc_cnt   <= we_ctrl ? 8'd0 : !en ? presc_cnt : wrap ? 8'd0 : presc_cnt + 8'd1;
      if (we_ctrl) begin
        en    <= timer_wr_data_i[0];
        presc <= timer_wr_data_i[15:8];
      end
      if (rd_lo) hi_shadow <= mtime[63:32];
      timer_irq_o <= irq_en_nx && (mtime_nx >= cmp_nx);
    end
  end
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: directed and random checks of mtimer against a cycle-level reference model.
module tb_mtimer;
  logic        clk_i = 0, rst_i = 0, wen = 0, ren = 0, irq;
  logic [19:0] wa = 0, ra = 0;
  logic [31:0] wd = 0, rd, last_rd;
  int          total = 0, bad = 0;
  logic [63:0] m_mt, m_cmp;
  logic        m_en, m_ie, m_irq;
  logic [7:0]  m_ps;
  int          m_cnt;
  logic [31:0] m_sh;
  always #5 clk_i = ~clk_i;
  mtimer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .timer_wr_en_i(wen), .timer_wr_addr_i(wa), .timer_wr_data_i(wd),
    .timer_rd_en_i(ren), .timer_rd_addr_i(ra), .timer_rd_data_o(rd),
    .timer_irq_o(irq)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int offs(input logic [19:0] a);
    return (a[19:5] == 0) ? int'(a[4:2]) : 7;
  endfunction
  function automatic logic [31:0] m_read(input logic [19:0] a);
    case (offs(a))
      0: return m_mt[31:0];
      1: return m_sh;
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {16'h0, m_ps, 6'h0, m_ie, m_en};
      5: return {31'h0, m_mt >= m_cmp};
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_reset();
    m_mt = 0; m_cmp = '1; m_en = 1; m_ie = 0; m_ps = 0; m_cnt = 0; m_sh = 0; m_irq = 0;
  endtask
  task automatic model_edge();
    int off;
    logic tk;
    logic [63:0] nt;
    off = wen ? offs(wa) : 8;
    if (ren && offs(ra) == 0) m_sh = m_mt[63:32];
    tk = m_en && m_cnt == int'(m_ps) && off != 4;
    if (off == 4) m_cnt = 0;
    else if (m_en) m_cnt = (m_cnt + 1) % (int'(m_ps) + 1);
    nt = tk ? m_mt + 1 : m_mt;
    if (off == 0) nt = {m_mt[63:32], wd};
    if (off == 1) nt = {wd, m_mt[31:0]};
    if (off == 2) m_cmp[31:0] = wd;
    if (off == 3) m_cmp[63:32] = wd;
    if (off == 4) begin m_en = wd[0]; m_ie = wd[1]; m_ps = wd[15:8]; end
    m_mt = nt;
    m_irq = m_ie && (m_mt >= m_cmp);
  endtask
  task automatic cyc(input logic we, input logic [19:0] a, input logic [31:0] d,
                     input logic re, input logic [19:0] r);
    wen = we; wa = a; wd = d; ren = re; ra = r;
    #3;
    last_rd = rd;
    check(re ? "rd" : "rd_idle", rd, re ? m_read(r) : 32'h0);
    @(posedge clk_i);
    model_edge();
    #1;
    check("irq", irq, m_irq);
    wen = 0; ren = 0;
  endtask
  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    cyc(1, a, d, 0, 0);
  endtask
  task automatic rdc(input logic [19:0] a);
    cyc(0, 0, 0, 1, a);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    logic [19:0] ad[4] = '{20'h0, 20'h8, 20'hC, 20'h10};
    logic [31:0] ex[4] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
    #2 rst_i = 0;
    model_reset();
    #1 check("rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) begin
      ren = 1; ra = ad[i];
      #1 check("rst_rd", rd, ex[i]);
    end
    ren = 0;
    @(posedge clk_i);
    #1 rst_i = 1;
  endtask
  initial begin
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1;
    // prescaler
    wr(20'h4, 0); wr(20'h0, 0); wr(20'h10, 32'h301);
    idle(3);
    rdc(0); check("presc_3", last_rd, 0);
    rdc(0); check("presc_4", last_rd, 1);
    idle(15);
    rdc(0); check("presc_20", last_rd, 5);
    wr(20'h10, 0); idle(50);
    rdc(0); check("frozen", last_rd, 5);
    // carry and atomic hi read
    wr(20'h10, 1); wr(20'h4, 0); wr(20'h0, 32'hFFFFFFFE);
    rdc(0); rdc(0);
    rdc(0); check("carry_lo", last_rd, 0);
    rdc(20'h4); check("carry_hi", last_rd, 1);
    wr(20'h4, 0); wr(20'h0, 32'hFFFFFFFF);
    rdc(0); check("snap_lo", last_rd, 32'hFFFFFFFF);
    idle(2);
    rdc(20'h4); check("snap_hi", last_rd, 0);
    // interrupt
    wr(20'h10, 3); wr(20'hC, 0); wr(20'h8, 100); wr(20'h4, 0); wr(20'h0, 0);
    idle(99); check("irq_99", irq, 0);
    idle(1); check("irq_100", irq, 1);
    wr(20'h8, 200); check("irq_cmp_up", irq, 0);
    rdc(20'h14); check("pend_0", last_rd, 0);
    wr(20'h8, 50); check("irq_again", irq, 1);
    wr(20'h10, 1); check("irq_dis", irq, 0);
    rdc(20'h14); check("pend_1", last_rd, 1);
    wr(20'h10, 3);
    do_reset();
    rdc(0); check("post_rst0", last_rd, 0);
    rdc(0); check("post_rst1", last_rd, 1);
    // write precedence and unmapped offsets
    wr(20'h0, 32'h10);
    rdc(0); check("wr_lo_tick", last_rd, 32'h10);
    wr(20'h18, 32'hFFFFFFFF);
    rdc(20'h18); check("rd_18", last_rd, 0);
    rdc(20'h10); check("ctrl_kept", last_rd, 1);
    rdc(20'h8); check("cmp_kept", last_rd, 32'hFFFFFFFF);
    // 64-bit wrap
    wr(20'h10, 3); wr(20'hC, 0); wr(20'h8, 0); wr(20'h4, 32'hFFFFFFFF); wr(20'h0, 32'hFFFFFFFF);
    idle(1); check("wrap_irq", irq, 1);
    wr(20'h10, 2); check("wrap_hold", irq, 1);
    wr(20'h8, 1); check("wrap_cmp1", irq, 0);
    rdc(0); check("wrap_lo", last_rd, 0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        we, re;
      logic [19:0] a, r;
      logic [31:0] d;
      we = $urandom_range(0, 9) < 3;
      re = $urandom_range(0, 9) < 6;
      a = {15'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 19) == 0) a = 20'($urandom);
      r = {15'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 19) == 0) r = 20'($urandom);
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 300));
        2: d = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        default: d = {16'h0, 8'($urandom_range(0, 3)), 6'h0, 1'($urandom), 1'($urandom_range(0, 7) != 0)};
      endcase
      if (we && a[4:2] == 3'd4 && $urandom_range(0, 3) != 0)
        d = {16'h0, 8'($urandom_range(0, 3)), 6'h0, 1'($urandom), 1'($urandom_range(0, 7) != 0)};
      cyc(we, a, d, re, r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
